// File: rtl/conv_mem_pkg.sv
// ---------------------------------------------------------------------------
// conv_mem_pkg
// Definitions shared by the scratchpad bridge and the convolution engine:
//   - accelerator memory operation codes (MEM_NONE/MEM_READ/MEM_WRITE/MEM_RSVD)
//   - the bridge FSM state type and its state constants
//   - the record latched for the one transaction in flight
//   - a helper that checks a word address against the scratchpad depth
// ---------------------------------------------------------------------------
package conv_mem_pkg;

   // Accelerator request code. 2'b10 is reserved and handled as an error no-op.
   typedef logic [1:0] mem_op_t;

   localparam mem_op_t MEM_NONE  = 2'b00;
   localparam mem_op_t MEM_READ  = 2'b01;
   localparam mem_op_t MEM_WRITE = 2'b11;
   localparam mem_op_t MEM_RSVD  = 2'b10;

   // Bridge FSM state. These are plain constants so older blocks can keep
   // using them directly.
   typedef logic [1:0] bridge_state_t;

   localparam bridge_state_t ST_IDLE   = 2'd0;
   localparam bridge_state_t ST_ACCESS = 2'd1;
   localparam bridge_state_t ST_RESP   = 2'd2;

   // Transaction captured at grant time. The host port's we bit is folded
   // into op, so the rest of the bridge only sees one kind of request.
   typedef struct packed {
      logic        owner_host;
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_txn_t;

   // True when a word address lies inside a scratchpad of 'depth' words.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input int unsigned depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/conv_mem_array.sv
// ---------------------------------------------------------------------------
// conv_mem_array
// Single-port synchronous scratchpad RAM, DEPTH x 32 bits, with a read
// pipeline of READ_LATENCY register stages. Contents are not reset.
//
// Ports
//   clk    in   clock
//   en     in   access strobe for this cycle
//   we     in   1 = write wdata to addr, 0 = read addr
//   addr   in   word address (AW bits)
//   wdata  in   write data
//   rdata  out  read data, valid READ_LATENCY cycles after a read strobe
// ---------------------------------------------------------------------------
module conv_mem_array #(
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 1,
   parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rd_pipe [READ_LATENCY];

   // Array port plus read pipeline. Stage 0 only loads on a read strobe, the
   // later stages shift every cycle; the bridge samples the last stage exactly
   // READ_LATENCY cycles after it issued the read, so the stale values held
   // between reads are never observed.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rd_pipe[0] <= mem[addr];
         end
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign rdata = rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/conv_mem_bridge.sv
// ---------------------------------------------------------------------------
// conv_mem_bridge
// Arbitrates the convolution accelerator and the host onto one shared
// scratchpad (conv_mem_array). Exactly one transaction is in flight.
//
// Ports
//   clk                in   clock
//   reset              in   synchronous, active-high reset
//   acc_mem_operation  in   00 none, 01 read, 11 write, 10 reserved
//   acc_addr           in   accelerator word address
//   acc_wdata          in   accelerator write data
//   acc_rdata          out  read data, valid while acc_opdone=1, else 0
//   acc_opdone         out  one-cycle completion pulse per acc transaction
//   host_req           in   host request level, held until host_ack
//   host_we            in   1 = write, 0 = read
//   host_addr          in   host word address
//   host_wdata         in   host write data
//   host_rdata         out  read data, valid while host_ack=1, else 0
//   host_ack           out  one-cycle completion pulse per host transaction
//   err                out  sticky: out-of-range address or reserved op seen
//
// Timing (request presented in cycle 0, sampled at the end of it):
//   read   : ACCESS cycles 1..READ_LATENCY, RESP, pulse in cycle RL+2
//   write  : ACCESS cycle 1, RESP cycle 2, pulse in cycle 3
//   op 10  : RESP cycle 1, pulse in cycle 2
// The pulse and its data are registered out of RESP, so they are visible in
// the following IDLE cycle; a requester that updates its request on that
// edge is sampled with the new values in that same IDLE cycle.
// ---------------------------------------------------------------------------
module conv_mem_bridge
   import conv_mem_pkg::*;
#(
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  acc_mem_operation,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   output logic [31:0] acc_rdata,
   output logic        acc_opdone,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        host_ack,
   output logic        err
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   bridge_state_t state;
   mem_txn_t      txn;
   mem_txn_t      grant_txn;
   logic [2:0]    lat_cnt;
   logic          last_host;
   logic          acc_pending;
   logic          host_pending;
   logic          grant_host;
   logic          grant_rsvd;
   logic          txn_in_range;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_rdata;
   logic [31:0]   resp_data;

   // Request decode and round-robin choice. The host keeps host_req high
   // through its ack cycle, so its request is ignored while host_ack is high
   // to avoid serving the same host transaction twice. When both ports are
   // pending the one that was not granted last wins.
   always_comb begin
      acc_pending  = (acc_mem_operation != MEM_NONE);
      host_pending = host_req && !host_ack;
      grant_host   = host_pending && (!acc_pending || !last_host);
      grant_txn    = '0;
      grant_txn.owner_host = grant_host;
      if (grant_host) begin
         grant_txn.op    = host_we ? MEM_WRITE : MEM_READ;
         grant_txn.addr  = host_addr;
         grant_txn.wdata = host_wdata;
      end else begin
         grant_txn.op    = acc_mem_operation;
         grant_txn.addr  = acc_addr;
         grant_txn.wdata = acc_wdata;
      end
      grant_rsvd = !grant_host && (acc_mem_operation == MEM_RSVD);
   end

   // Scratchpad strobe: issued once, in the first ACCESS cycle, and only for
   // in-range addresses. Gating with reset keeps a write whose ACCESS cycle
   // coincides with reset from being committed.
   always_comb begin
      txn_in_range = addr_in_range(txn.addr, DEPTH);
      ram_en       = (state == ST_ACCESS) && (lat_cnt == 3'd0) &&
                     txn_in_range && !reset;
      ram_we       = (txn.op == MEM_WRITE);
      ram_addr     = txn.addr[AW-1:0];
      resp_data    = ((txn.op == MEM_READ) && txn_in_range) ? ram_rdata : 32'd0;
   end

   conv_mem_array #(
      .DEPTH        (DEPTH),
      .READ_LATENCY (READ_LATENCY),
      .AW           (AW)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (txn.wdata),
      .rdata (ram_rdata)
   );

   // Transaction FSM and registered outputs. Pulses and read data default to
   // zero every cycle and are set only on the RESP -> IDLE edge for the
   // owning port, which gives the single-cycle pulse and the zero rdata on
   // the idle port. Reads wait in ACCESS until the array pipeline has the
   // data; writes and out-of-range accesses still follow the normal timing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         txn        <= '0;
         lat_cnt    <= 3'd0;
         last_host  <= 1'b1;
         err        <= 1'b0;
         acc_opdone <= 1'b0;
         acc_rdata  <= 32'd0;
         host_ack   <= 1'b0;
         host_rdata <= 32'd0;
      end else begin
         acc_opdone <= 1'b0;
         acc_rdata  <= 32'd0;
         host_ack   <= 1'b0;
         host_rdata <= 32'd0;
         case (state)
            ST_IDLE: begin
               if (acc_pending || host_pending) begin
                  txn       <= grant_txn;
                  last_host <= grant_host;
                  lat_cnt   <= 3'd0;
                  if (grant_rsvd || !addr_in_range(grant_txn.addr, DEPTH)) begin
                     err <= 1'b1;
                  end
                  state <= grant_rsvd ? ST_RESP : ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if ((txn.op == MEM_READ) && (lat_cnt != LAT_LAST)) begin
                  lat_cnt <= lat_cnt + 3'd1;
               end else begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (txn.owner_host) begin
                  host_ack   <= 1'b1;
                  host_rdata <= resp_data;
               end else begin
                  acc_opdone <= 1'b1;
                  acc_rdata  <= resp_data;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_conv_mem_bridge
// Self-checking bench for conv_mem_bridge. Two instances share clock and
// reset: dut (READ_LATENCY=1) carries most tests, dut3 (READ_LATENCY=3) the
// longer-latency timing. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_conv_mem_bridge;
   import conv_mem_pkg::*;

   localparam int DEPTH = 256;
   localparam int RL    = 1;
   localparam int RL3   = 3;

   logic        clk = 1'b0;
   logic        reset;

   logic [1:0]  acc_op,    acc_op3;
   logic [31:0] acc_addr,  acc_addr3, acc_wdata, acc_wdata3;
   logic [31:0] acc_rdata, acc_rdata3;
   logic        acc_opdone, acc_opdone3;
   logic        host_req,  host_req3, host_we, host_we3;
   logic [31:0] host_addr, host_addr3, host_wdata, host_wdata3;
   logic [31:0] host_rdata, host_rdata3;
   logic        host_ack,  host_ack3;
   logic        err,       err3;

   int total = 0;
   int bad   = 0;

   // reference model of the scratchpad and the sticky error flag
   logic [31:0] mem_model [DEPTH];
   bit          mem_known [DEPTH];
   bit          err_model;

   typedef struct {
      bit          is_host;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      bit          exp_err;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   conv_mem_bridge #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
      .clk               (clk),
      .reset             (reset),
      .acc_mem_operation (acc_op),
      .acc_addr          (acc_addr),
      .acc_wdata         (acc_wdata),
      .acc_rdata         (acc_rdata),
      .acc_opdone        (acc_opdone),
      .host_req          (host_req),
      .host_we           (host_we),
      .host_addr         (host_addr),
      .host_wdata        (host_wdata),
      .host_rdata        (host_rdata),
      .host_ack          (host_ack),
      .err               (err)
   );

   conv_mem_bridge #(.DEPTH(DEPTH), .READ_LATENCY(RL3)) dut3 (
      .clk               (clk),
      .reset             (reset),
      .acc_mem_operation (acc_op3),
      .acc_addr          (acc_addr3),
      .acc_wdata         (acc_wdata3),
      .acc_rdata         (acc_rdata3),
      .acc_opdone        (acc_opdone3),
      .host_req          (host_req3),
      .host_we           (host_we3),
      .host_addr         (host_addr3),
      .host_wdata        (host_wdata3),
      .host_rdata        (host_rdata3),
      .host_ack          (host_ack3),
      .err               (err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Higher-level reference: latency from the op kind, data from an array.
   task automatic model_txn(input bit is_host, input logic [1:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rdata, output int exp_lat,
                            output bit rd_known);
      bit in_range = (addr < DEPTH);
      exp_rdata = 32'd0;
      rd_known  = 1'b1;
      if (!is_host && op == MEM_RSVD) begin
         exp_lat   = 2;
         err_model = 1'b1;
      end else begin
         exp_lat = (op == MEM_READ) ? RL + 2 : 3;
         if (!in_range) begin
            err_model = 1'b1;
         end else if (op == MEM_WRITE) begin
            mem_model[addr[7:0]] = wdata;
            mem_known[addr[7:0]] = 1'b1;
         end else begin
            rd_known  = mem_known[addr[7:0]];
            exp_rdata = mem_model[addr[7:0]];
         end
      end
   endtask

   // Drive one request on dut (sel3=0) or dut3 (sel3=1), wait for its pulse,
   // check the other port stays quiet, then withdraw the request.
   task automatic apply_stimulus(input bit sel3, input bit is_host,
                                 input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int lat);
      bit          done = 1'b0;
      logic        my_pulse, other_pulse;
      logic [31:0] my_rdata, other_rdata;
      lat   = 0;
      rdata = 32'd0;
      if (sel3) begin
         if (is_host) begin
            host_req3 = 1'b1; host_we3 = (op == MEM_WRITE);
            host_addr3 = addr; host_wdata3 = wdata;
         end else begin
            acc_op3 = op; acc_addr3 = addr; acc_wdata3 = wdata;
         end
      end else begin
         if (is_host) begin
            host_req = 1'b1; host_we = (op == MEM_WRITE);
            host_addr = addr; host_wdata = wdata;
         end else begin
            acc_op = op; acc_addr = addr; acc_wdata = wdata;
         end
      end
      while (!done && lat < 20) begin
         tick();
         lat++;
         if (sel3) begin
            my_pulse    = is_host ? host_ack3   : acc_opdone3;
            my_rdata    = is_host ? host_rdata3 : acc_rdata3;
            other_pulse = is_host ? acc_opdone3 : host_ack3;
            other_rdata = is_host ? acc_rdata3  : host_rdata3;
         end else begin
            my_pulse    = is_host ? host_ack   : acc_opdone;
            my_rdata    = is_host ? host_rdata : acc_rdata;
            other_pulse = is_host ? acc_opdone : host_ack;
            other_rdata = is_host ? acc_rdata  : host_rdata;
         end
         if (my_pulse) begin
            done  = 1'b1;
            rdata = my_rdata;
            check_output("idle port pulse", 32'(other_pulse), 32'd0);
            check_output("idle port rdata", other_rdata, 32'd0);
         end
      end
      if (!done) lat = 99;
      if (sel3) begin
         host_req3 = 1'b0; acc_op3 = MEM_NONE;
      end else begin
         host_req = 1'b0; acc_op = MEM_NONE;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      acc_op = MEM_NONE;  host_req = 1'b0;
      acc_op3 = MEM_NONE; host_req3 = 1'b0;
      tick();
      tick();
      check_output("reset acc_opdone", 32'(acc_opdone), 32'd0);
      check_output("reset host_ack", 32'(host_ack), 32'd0);
      check_output("reset acc_rdata", acc_rdata, 32'd0);
      check_output("reset host_rdata", host_rdata, 32'd0);
      check_output("reset err", 32'(err), 32'd0);
      check_output("reset err3", 32'(err3), 32'd0);
      reset = 1'b0;
      err_model = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rdata, exp_rdata;
      int          lat, exp_lat, cyc, prev, n, pulses;
      bit          rd_known, is_host;
      logic [1:0]  op;
      logic [31:0] addr, wdata;

      reset = 1'b1;
      acc_op = MEM_NONE;  acc_addr = '0;  acc_wdata = '0;
      host_req = 1'b0;    host_we = 1'b0; host_addr = '0;  host_wdata = '0;
      acc_op3 = MEM_NONE; acc_addr3 = '0; acc_wdata3 = '0;
      host_req3 = 1'b0;   host_we3 = 1'b0; host_addr3 = '0; host_wdata3 = '0;
      err_model = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_known[i] = 1'b0;

      vecs[0]  = '{1'b1, MEM_WRITE, 32'd1,   32'd3,         32'd0,         3, 1'b0};
      vecs[1]  = '{1'b1, MEM_WRITE, 32'd2,   32'd3,         32'd0,         3, 1'b0};
      vecs[2]  = '{1'b1, MEM_WRITE, 32'd3,   32'd3,         32'd0,         3, 1'b0};
      vecs[3]  = '{1'b1, MEM_WRITE, 32'd4,   32'd3,         32'd0,         3, 1'b0};
      vecs[4]  = '{1'b0, MEM_WRITE, 32'h20,  32'h0000_002A, 32'd0,         3, 1'b0};
      vecs[5]  = '{1'b1, MEM_READ,  32'h20,  32'd0,         32'h0000_002A, 3, 1'b0};
      vecs[6]  = '{1'b0, MEM_READ,  32'd1,   32'd0,         32'd3,         3, 1'b0};
      vecs[7]  = '{1'b1, MEM_WRITE, 32'd5,   32'd7,         32'd0,         3, 1'b0};
      vecs[8]  = '{1'b0, MEM_READ,  32'd5,   32'd0,         32'd7,         3, 1'b0};
      vecs[9]  = '{1'b1, MEM_WRITE, 32'd255, 32'hCAFE_F00D, 32'd0,         3, 1'b0};
      vecs[10] = '{1'b0, MEM_READ,  32'd255, 32'd0,         32'hCAFE_F00D, 3, 1'b0};
      vecs[11] = '{1'b0, MEM_WRITE, 32'd0,   32'h1234_5678, 32'd0,         3, 1'b0};
      vecs[12] = '{1'b1, MEM_READ,  32'd0,   32'd0,         32'h1234_5678, 3, 1'b0};

      tick();
      do_reset();

      // table of single transactions
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(1'b0, vecs[i].is_host, vecs[i].op, vecs[i].addr,
                        vecs[i].wdata, rdata, lat);
         check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
         check_output($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         check_output($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
         model_txn(vecs[i].is_host, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   exp_rdata, exp_lat, rd_known);
         tick();
         check_output($sformatf("vec%0d pulse width", i),
                      32'(acc_opdone | host_ack), 32'd0);
      end

      // back-to-back accelerator reads, address bumped on each opdone
      acc_op = MEM_READ; acc_addr = 32'd1;
      cyc = 0; prev = 0; n = 0;
      while (n < 4 && cyc < 40) begin
         tick();
         cyc++;
         if (acc_opdone) begin
            check_output($sformatf("b2b rdata %0d", n), acc_rdata, 32'd3);
            check_output($sformatf("b2b spacing %0d", n), cyc - prev, 32'd3);
            prev = cyc;
            n++;
            acc_addr = acc_addr + 32'd1;
         end
      end
      acc_op = MEM_NONE;
      check_output("b2b count", n, 32'd4);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (acc_opdone || host_ack) pulses++;
      end
      check_output("b2b no extra pulse", pulses, 32'd0);

      // reset during ACCESS of a write to addr 5 (holds 7)
      acc_op = MEM_WRITE; acc_addr = 32'd5; acc_wdata = 32'h99;
      tick();
      reset = 1'b1; acc_op = MEM_NONE;
      tick();
      reset = 1'b0;
      err_model = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (acc_opdone) pulses++;
      end
      check_output("aborted write pulses", pulses, 32'd0);
      apply_stimulus(1'b0, 1'b1, MEM_READ, 32'd5, 32'd0, rdata, lat);
      check_output("aborted write addr5", rdata, 32'd7);
      check_output("aborted write err", 32'(err), 32'd0);
      tick();

      // out-of-range accesses
      apply_stimulus(1'b0, 1'b0, MEM_READ, 32'h100, 32'd0, rdata, lat);
      check_output("oor read rdata", rdata, 32'd0);
      check_output("oor read latency", lat, 32'd3);
      check_output("oor read err", 32'(err), 32'd1);
      tick();
      apply_stimulus(1'b0, 1'b1, MEM_WRITE, 32'h120, 32'h55, rdata, lat);
      check_output("oor write latency", lat, 32'd3);
      tick();
      apply_stimulus(1'b0, 1'b1, MEM_READ, 32'h20, 32'd0, rdata, lat);
      check_output("oor write dropped", rdata, 32'h0000_002A);
      for (int i = 0; i < 5; i++) tick();
      check_output("err sticky", 32'(err), 32'd1);
      do_reset();

      // scratchpad survives reset
      apply_stimulus(1'b0, 1'b1, MEM_READ, 32'h20, 32'd0, rdata, lat);
      check_output("contents after reset", rdata, 32'h0000_002A);
      tick();
      do_reset();

      // simultaneous requests: grants alternate starting with the accelerator
      acc_op = MEM_READ; acc_addr = 32'd1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
      cyc = 0; n = 0;
      while (n < 6 && cyc < 60) begin
         tick();
         cyc++;
         if (acc_opdone) begin
            check_output($sformatf("rr owner %0d", n), 32'd0, n % 2);
            check_output($sformatf("rr acc rdata %0d", n), acc_rdata, 32'd3);
            check_output($sformatf("rr timing %0d", n), cyc, 3 * (n + 1));
            n++;
         end
         if (host_ack) begin
            check_output($sformatf("rr owner %0d", n), 32'd1, n % 2);
            check_output($sformatf("rr host rdata %0d", n), host_rdata, 32'h2A);
            check_output($sformatf("rr timing %0d", n), cyc, 3 * (n + 1));
            n++;
            host_req = 1'b0;
         end else begin
            host_req = (n < 6);
         end
      end
      acc_op = MEM_NONE; host_req = 1'b0;
      check_output("rr count", n, 32'd6);
      for (int i = 0; i < 6; i++) tick();

      // READ_LATENCY=3 instance
      apply_stimulus(1'b1, 1'b0, MEM_WRITE, 32'd2, 32'h0000_1234, rdata, lat);
      check_output("rl3 write latency", lat, 32'd3);
      tick();
      apply_stimulus(1'b1, 1'b0, MEM_READ, 32'd2, 32'd0, rdata, lat);
      check_output("rl3 read latency", lat, 32'd5);
      check_output("rl3 read rdata", rdata, 32'h0000_1234);
      check_output("rl3 err clean", 32'(err3), 32'd0);
      tick();
      apply_stimulus(1'b1, 1'b1, MEM_READ, 32'd2, 32'd0, rdata, lat);
      check_output("rl3 host read latency", lat, 32'd5);
      check_output("rl3 host read rdata", rdata, 32'h0000_1234);
      tick();
      apply_stimulus(1'b1, 1'b0, MEM_RSVD, 32'd2, 32'd0, rdata, lat);
      check_output("rl3 rsvd latency", lat, 32'd2);
      check_output("rl3 rsvd rdata", rdata, 32'd0);
      check_output("rl3 rsvd err", 32'(err3), 32'd1);
      tick();
      do_reset();

      // randomized transactions against the reference model
      for (int i = 0; i < 80; i++) begin
         is_host = 1'($urandom_range(0, 1));
         if (is_host) begin
            op = ($urandom_range(0, 1) == 0) ? MEM_WRITE : MEM_READ;
         end else begin
            case ($urandom_range(0, 9))
               0:       op = MEM_RSVD;
               1, 2, 3: op = MEM_WRITE;
               default: op = MEM_READ;
            endcase
         end
         case ($urandom_range(0, 7))
            0:       addr = 32'(DEPTH + $urandom_range(0, 300));
            1:       addr = $urandom;
            default: addr = 32'($urandom_range(0, DEPTH - 1));
         endcase
         wdata = $urandom;
         model_txn(is_host, op, addr, wdata, exp_rdata, exp_lat, rd_known);
         apply_stimulus(1'b0, is_host, op, addr, wdata, rdata, lat);
         check_output($sformatf("rand%0d latency", i), lat, exp_lat);
         if (rd_known) begin
            check_output($sformatf("rand%0d rdata", i), rdata, exp_rdata);
         end
         check_output($sformatf("rand%0d err", i), 32'(err), 32'(err_model));
         tick();
         check_output($sformatf("rand%0d pulse width", i),
                      32'(acc_opdone | host_ack), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_mem_bridge.md
CONV_MEM_BRIDGE -- requirements
Module: conv_mem_bridge

Interface
REQ-001 DEPTH, default 256, word count of the internal scratchpad (32-bit words).
REQ-002 READ_LATENCY, default 1, cycles from array access start to read data valid (range 1..4).
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 acc_mem_operation  input  2  accelerator request code: 00 none, 01 read, 11 write, 10 reserved.
REQ-006 acc_addr  input  32  accelerator word address.
REQ-007 acc_wdata  input  32  accelerator write data.
REQ-008 acc_rdata  output  32  read data, valid while acc_opdone=1.
REQ-009 acc_opdone  output  1  one-cycle completion pulse per accelerator transaction.
REQ-010 host_req  input  1  host request, level, held until host_ack.
REQ-011 host_we  input  1  1 = write, 0 = read.
REQ-012 host_addr  input  32  host word address.
REQ-013 host_wdata  input  32  host write data.
REQ-014 host_rdata  output  32  read data, valid while host_ack=1.
REQ-015 host_ack  output  1  one-cycle completion pulse per host transaction.
REQ-016 err  output  1  sticky: out-of-range address or reserved op code seen.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-018 IDLE samples requests each cycle; a request starts a transaction by latching owner, op, addr, wdata and moving to ACCESS.
REQ-019 Arbitration in IDLE: if both pending, grant the port not granted last (round robin, initial favour accelerator); if one pending, grant it.
REQ-020 ACCESS lasts READ_LATENCY cycles for reads and exactly 1 cycle for writes, then RESP.
REQ-021 RESP drives the owner's opdone/ack high for exactly one cycle, with rdata registered, then returns to IDLE; no grant is made in the RESP cycle.
REQ-022 Requests are re-sampled only in IDLE, so a requester that updates addr on the opdone edge is served with the new address next cycle.
REQ-023 Accelerator write: array[addr] <= acc_wdata at the ACCESS cycle; acc_rdata = 0 in RESP.
REQ-024 Address range: addr >= DEPTH -> write dropped, read returns 0, err set, opdone/ack still pulsed normally.
REQ-025 acc_mem_operation = 10 -> treated as one-cycle no-op transaction: err set, acc_opdone pulsed via RESP.
REQ-026 Request withdrawn (op 00 or host_req 0) after grant: transaction still completes and pulses; no abort.
REQ-027 Non-owner outputs: opdone/ack 0, rdata 0.
REQ-028 Minimum accelerator read turnaround = READ_LATENCY + 2 cycles from request sample to opdone.

Reset
REQ-029 reset forces state IDLE, acc_opdone 0, host_ack 0, acc_rdata 0, host_rdata 0, err 0, round-robin pointer to "accelerator last lost".
REQ-030 reset mid-transaction abandons it with no pulse; a pending write in ACCESS during reset is not committed.
REQ-031 Array contents are not cleared by reset.

Structure
REQ-032 Shared package conv_mem_pkg holds op codes MEM_NONE/MEM_READ/MEM_WRITE/MEM_RSVD and the FSM state type, reused by the convolution engine.
REQ-033 One sub-module conv_mem_array: single-port synchronous RAM, DEPTH x 32, parameterised latency pipeline.

Verification
REQ-034 Host writes 3,3,3,3 to addr 1..4, then accelerator reads addr 1..4 back-to-back holding op 01 and incrementing addr on each opdone -> acc_rdata 3,3,3,3, one pulse each, 3 cycles apart at READ_LATENCY=1.
REQ-035 Host and accelerator request in the same cycle, repeatedly -> grants alternate acc, host, acc, host; neither waits more than one transaction.
REQ-036 Accelerator write 0x0000_002A to addr 0x20, host read 0x20 -> host_rdata 0x2A, acc_rdata stays 0.
REQ-037 Accelerator read addr 0x100 with DEPTH=256 -> acc_rdata 0, opdone pulsed, err=1 and stays 1 until reset.
REQ-038 reset asserted during ACCESS of a write to addr 5 (previously 7) -> no opdone, addr 5 still reads 7, err 0.
REQ-039 READ_LATENCY=3: accelerator read -> opdone exactly 5 cycles after request sample; op 10 -> opdone after 2 cycles and err=1.
